// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS-subset core: 16 registers, word-addressed imem, stalling dmem handshake.
// Optional macro MIPS_MC_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
//
// state    | meaning
// FETCH    | latch imem_data into IR, pc+1
// DECODE   | read rs/rt into A/B, trap illegal opcodes
// EXEC     | ALU op, address calc, branch/jump resolution
// MEM      | hold dmem request until dmem_ready
// WB       | write ALU result or load data to rd/rt
// HALT     | stopped on illegal instruction until rst
module mips_multicycle_core #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [PC_W-1:0]   pc,
    output logic              halted
`ifdef MIPS_MC_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [31:0]        r_ir;
    logic [DATA_W-1:0]  r_a, r_b, r_alu, r_mdr;
    logic [DATA_W-1:0]  r_regs [16];

    logic [5:0]         w_op, w_func;
    logic [3:0]         w_rs, w_rt, w_rd, w_shamt, w_dest;
    logic [15:0]        w_imm;
    logic [9:0]         w_jaddr;
    logic [DATA_W-1:0]  w_imm_sx, w_imm_zx, w_alu, w_rs_val, w_rt_val;
    logic [PC_W-1:0]    w_imm_pc, w_jaddr_pc;
    logic               w_legal, w_is_mem, w_is_ctrl, w_taken;
    logic               w_unused_ir;

    assign w_op        = r_ir[31:26];
    assign w_rs        = r_ir[25:22];
    assign w_rt        = r_ir[21:18];
    assign w_rd        = r_ir[17:14];
    assign w_shamt     = r_ir[13:10];
    assign w_func      = r_ir[9:4];
    assign w_imm       = r_ir[17:2];
    assign w_jaddr     = r_ir[25:16];
    assign w_unused_ir = ^r_ir[1:0];

    assign w_imm_sx   = DATA_W'($signed(w_imm));
    assign w_imm_zx   = DATA_W'(w_imm);
    assign w_imm_pc   = PC_W'($signed(w_imm));
    assign w_jaddr_pc = PC_W'(w_jaddr);
    assign w_dest     = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_rs_val   = (w_rs == 4'd0) ? '0 : r_regs[w_rs];
    assign w_rt_val   = (w_rt == 4'd0) ? '0 : r_regs[w_rt];
    assign w_is_mem   = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_is_ctrl  = (w_op == OP_BEQ) || (w_op == OP_BNE) || (w_op == OP_J);
    assign w_taken    = ((w_op == OP_BEQ) && (r_a == r_b)) ||
                        ((w_op == OP_BNE) && (r_a != r_b));

    // Legality is judged from IR in DECODE; the ALU result is consumed in EXEC.
    always_comb begin
        w_legal = 1'b0;
        w_alu   = '0;
        case (w_op)
            OP_RTYPE: begin
                w_legal = 1'b1;
                case (w_func)
                    6'b100000: w_alu = r_a + r_b;
                    6'b100010: w_alu = r_a - r_b;
                    6'b100100: w_alu = r_a & r_b;
                    6'b100101: w_alu = r_a | r_b;
                    6'b101010: w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                    6'b000000: w_alu = r_b << w_shamt;
                    6'b000010: w_alu = r_b >> w_shamt;
                    default:   w_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                w_legal = 1'b1;
                w_alu   = r_a + w_imm_sx;
            end
            OP_ANDI: begin
                w_legal = 1'b1;
                w_alu   = r_a & w_imm_zx;
            end
            OP_ORI: begin
                w_legal = 1'b1;
                w_alu   = r_a | w_imm_zx;
            end
            OP_BEQ, OP_BNE, OP_J: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_HALT;
            S_EXEC:   w_state_nxt = w_is_mem ? S_MEM : (w_is_ctrl ? S_FETCH : S_WB);
            S_MEM:    if (dmem_ready) w_state_nxt = (w_op == OP_LW) ? S_WB : S_FETCH;
            S_WB:     w_state_nxt = S_FETCH;
            default:  w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_mdr <= '0;
            for (int i = 0; i < 16; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= imem_data;
                    r_pc <= r_pc + 1'b1;
                end
                S_DECODE: begin
                    r_a <= w_rs_val;
                    r_b <= w_rt_val;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (w_taken)         r_pc <= r_pc + w_imm_pc;
                    else if (w_op == OP_J) r_pc <= w_jaddr_pc;
                end
                S_MEM: if (dmem_ready) r_mdr <= dmem_rdata;
                S_WB: if (w_dest != 4'd0) r_regs[w_dest] <= (w_op == OP_LW) ? r_mdr : r_alu;
                default: ;
            endcase
        end
    end

`ifdef MIPS_MC_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            retired <= '0;
        else if ((w_state_nxt == S_FETCH) &&
                 ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)))
            retired <= retired + 32'd1;
    end
`endif

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign halted     = (r_state == S_HALT);
    assign dmem_req   = (r_state == S_MEM);
    assign dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign dmem_addr  = r_alu;
    assign dmem_wdata = r_b;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: store scoreboard plus pc/halt timing checks.
// Connects the retired port when MIPS_MC_RETIRE_CNT_EN is defined.
module tb_mips_multicycle_core;

    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [9:0]  pc;
    logic        halted;
`ifdef MIPS_MC_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    logic [31:0] imem [1024];
    logic [15:0] dmem [256];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          hold;
    } st_t;
    st_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int wait_cfg = 0;
    int wcnt     = 0;
    int hold     = 0;

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr];

    mips_multicycle_core #(.DATA_W(16), .PC_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .pc         (pc),
        .halted     (halted)
`ifdef MIPS_MC_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [3:0] rs,
                                         input logic [3:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm, 2'b00};
    endfunction

    function automatic logic [31:0] r_op(input logic [3:0] rs, input logic [3:0] rt,
                                         input logic [3:0] rd, input logic [3:0] sh,
                                         input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn, 4'b0000};
    endfunction

    function automatic logic [31:0] j_op(input logic [9:0] addr);
        return {6'b000010, addr, 16'h0000};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_reset();
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
        sb_q.delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Data-memory responder: ready after wait_cfg wait cycles, stores scored on acceptance.
    initial begin
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        forever begin
            @(negedge clk);
            if (!dmem_req || rst) begin
                dmem_ready = 1'b0;
                wcnt = 0;
                hold = 0;
            end else if (dmem_ready) begin
                dmem_ready = 1'b0;
            end else begin
                hold++;
                if (wcnt < wait_cfg) begin
                    wcnt++;
                end else begin
                    dmem_ready = 1'b1;
                    dmem_rdata = dmem[dmem_addr[7:0]];
                    if (dmem_we) begin
                        dmem[dmem_addr[7:0]] = dmem_wdata;
                        if (sb_q.size() == 0) begin
                            chk("sb_unexpected_store", 32'(dmem_addr), 32'hFFFF_FFFF);
                        end else begin
                            st_t e;
                            e = sb_q.pop_front();
                            chk("st_addr", 32'(dmem_addr), 32'(e.addr));
                            chk("st_data", 32'(dmem_wdata), 32'(e.data));
                            chk("st_hold", 32'(hold), 32'(e.hold));
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Program A: ALU ops, stalled sw/lw, r0 behaviour, then illegal opcode at 24.
        start_reset();
        wait_cfg = 3;
        imem[0]  = i_op(OP_ADDI, 0, 1, 16'd5);
        imem[1]  = i_op(OP_ADDI, 0, 2, 16'hFFFD);
        imem[2]  = r_op(1, 2, 3, 0, 6'b100000);
        imem[3]  = i_op(OP_SW, 0, 3, 16'd0);
        imem[4]  = i_op(OP_SW, 0, 1, 16'd4);
        imem[5]  = i_op(OP_LW, 0, 4, 16'd4);
        imem[6]  = i_op(OP_SW, 0, 4, 16'd8);
        imem[7]  = i_op(OP_ADDI, 0, 0, 16'd9);
        imem[8]  = r_op(0, 0, 5, 0, 6'b100000);
        imem[9]  = i_op(OP_SW, 0, 5, 16'd12);
        imem[10] = r_op(2, 1, 6, 0, 6'b101010);
        imem[11] = i_op(OP_SW, 0, 6, 16'd16);
        imem[12] = r_op(2, 1, 7, 0, 6'b100010);
        imem[13] = i_op(OP_SW, 0, 7, 16'd20);
        imem[14] = r_op(0, 1, 8, 3, 6'b000000);
        imem[15] = i_op(OP_SW, 0, 8, 16'd24);
        imem[16] = r_op(0, 2, 9, 4, 6'b000010);
        imem[17] = i_op(OP_SW, 0, 9, 16'd28);
        imem[18] = r_op(1, 2, 10, 0, 6'b100101);
        imem[19] = i_op(OP_SW, 0, 10, 16'd32);
        imem[20] = i_op(OP_ANDI, 2, 11, 16'h00F0);
        imem[21] = i_op(OP_SW, 0, 11, 16'd36);
        imem[22] = i_op(OP_ORI, 1, 12, 16'h8000);
        imem[23] = i_op(OP_SW, 3, 12, 16'hFFFE);
        imem[24] = 32'hFC00_0000;
        sb_q.push_back('{16'd0,  16'h0002, 4});
        sb_q.push_back('{16'd4,  16'h0005, 4});
        sb_q.push_back('{16'd8,  16'h0005, 4});
        sb_q.push_back('{16'd12, 16'h0000, 4});
        sb_q.push_back('{16'd16, 16'h0001, 4});
        sb_q.push_back('{16'd20, 16'hFFF8, 4});
        sb_q.push_back('{16'd24, 16'h0028, 4});
        sb_q.push_back('{16'd28, 16'h0FFF, 4});
        sb_q.push_back('{16'd32, 16'hFFFD, 4});
        sb_q.push_back('{16'd36, 16'h00F0, 4});
        sb_q.push_back('{16'd0,  16'h8005, 4});
        step(1);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_we", 32'(dmem_we), 32'd0);
`ifdef MIPS_MC_RETIRE_CNT_EN
        chk("rst_retired", retired, 32'd0);
`endif
        release_reset();
        step(12);
        chk("a_pc_after_3_alu", 32'(pc), 32'd3);
        for (int i = 0; i < 3000 && !halted; i++) step(1);
        chk("a_halted", 32'(halted), 32'd1);
        chk("a_halt_pc", 32'(pc), 32'd25);
        chk("a_sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef MIPS_MC_RETIRE_CNT_EN
        chk("a_retired", retired, 32'd24);
`endif
        step(5);
        chk("a_pc_frozen", 32'(pc), 32'd25);
        chk("a_req_idle", 32'(dmem_req), 32'd0);

        // Program B: jump, not-taken/taken bne, self-looping beq.
        start_reset();
        imem[0]  = i_op(OP_ADDI, 0, 1, 16'd5);
        imem[1]  = j_op(10'd7);
        imem[7]  = i_op(OP_BNE, 1, 1, 16'd4);
        imem[8]  = i_op(OP_BNE, 1, 0, 16'd4);
        imem[13] = i_op(OP_BEQ, 1, 1, 16'hFFFF);
        release_reset();
        step(4);
        chk("b_pc_addi", 32'(pc), 32'd1);
        step(3);
        chk("b_pc_jump", 32'(pc), 32'd7);
        step(3);
        chk("b_pc_bne_nt", 32'(pc), 32'd8);
        step(3);
        chk("b_pc_bne_t", 32'(pc), 32'd13);
        step(1);
        chk("b_pc_beq_fetch", 32'(pc), 32'd14);
        step(2);
        chk("b_pc_beq_loop", 32'(pc), 32'd13);
`ifdef MIPS_MC_RETIRE_CNT_EN
        chk("b_retired5", retired, 32'd5);
`endif
        step(3);
        chk("b_pc_beq_loop2", 32'(pc), 32'd13);

        // Program C: illegal opcode at pc=2, then reset out of HALT.
        start_reset();
        imem[0] = i_op(OP_ADDI, 0, 1, 16'd1);
        imem[1] = i_op(OP_ADDI, 0, 2, 16'd2);
        imem[2] = 32'hFC00_0000;
        release_reset();
        step(8);
        chk("c_pc2", 32'(pc), 32'd2);
        step(1);
        chk("c_not_yet_halted", 32'(halted), 32'd0);
        step(1);
        chk("c_halted", 32'(halted), 32'd1);
        chk("c_halt_pc", 32'(pc), 32'd3);
        step(10);
        chk("c_pc_frozen", 32'(pc), 32'd3);
        rst = 1'b1;
        step(1);
        chk("c_rst_halted", 32'(halted), 32'd0);
        chk("c_rst_pc", 32'(pc), 32'd0);

        // Program D: R-type with an undefined func traps.
        start_reset();
        imem[0] = r_op(1, 2, 3, 0, 6'b111111);
        release_reset();
        step(2);
        chk("d_halted", 32'(halted), 32'd1);
        chk("d_pc", 32'(pc), 32'd1);

        // Program E: zero-wait sw, then reset while a stalled sw sits in MEM.
        start_reset();
        wait_cfg = 0;
        imem[0] = i_op(OP_ADDI, 0, 1, 16'd7);
        imem[1] = i_op(OP_SW, 0, 1, 16'd6);
        imem[2] = i_op(OP_SW, 0, 1, 16'd10);
        sb_q.push_back('{16'd6, 16'h0007, 1});
        release_reset();
        step(8);
        chk("e_pc_after_sw0", 32'(pc), 32'd2);
        chk("e_sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef MIPS_MC_RETIRE_CNT_EN
        chk("e_retired2", retired, 32'd2);
`endif
        wait_cfg = 1000;
        step(4);
        chk("e_req_held", 32'(dmem_req), 32'd1);
        chk("e_we_held", 32'(dmem_we), 32'd1);
        chk("e_addr_held", 32'(dmem_addr), 32'd10);
        chk("e_wdata_held", 32'(dmem_wdata), 32'd7);
        rst = 1'b1;
        step(1);
        chk("e_rst_req", 32'(dmem_req), 32'd0);
        chk("e_rst_we", 32'(dmem_we), 32'd0);
        chk("e_rst_pc", 32'(pc), 32'd0);
`ifdef MIPS_MC_RETIRE_CNT_EN
        chk("e_rst_retired", retired, 32'd0);
`endif
        wait_cfg = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter DATA_W, default 16, datapath, register and data-memory word width (>=8).
REQ-002 Parameter PC_W, default 10, instruction-address width, word addressed.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 imem_addr  output  PC_W  instruction address, equals pc.
REQ-006 imem_data  input  32  instruction word, combinational read of imem_addr.
REQ-007 dmem_req  output  1  data-memory request, held until accepted.
REQ-008 dmem_we  output  1  1=store, 0=load, valid while dmem_req.
REQ-009 dmem_addr  output  DATA_W  ALU result address, stable while dmem_req.
REQ-010 dmem_wdata  output  DATA_W  rt content, stable while dmem_req.
REQ-011 dmem_rdata  input  DATA_W  load data, sampled in the cycle dmem_ready=1.
REQ-012 dmem_ready  input  1  completes the pending request.
REQ-013 pc  output  PC_W  current program counter.
REQ-014 halted  output  1  core stopped on an illegal opcode.

Function
REQ-015 Instruction fields: opcode[31:26], rs[25:22], rt[21:18], rd[17:14], shamt[13:10], func[9:4], imm[17:2] (16 bits), jaddr[25:16].
REQ-016 FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle except MEM.
REQ-017 FETCH: latch imem_data into IR, pc <= pc+1 (mod 2^PC_W) -> DECODE.
REQ-018 DECODE: latch rs/rt contents into A/B; illegal opcode -> HALT, else -> EXEC.
REQ-019 EXEC: ALU/branch/jump; lw/sw -> MEM; ALU ops -> WB; beq/bne/j -> FETCH.
REQ-020 R-type (opcode 000000) func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed), 000000 sll by shamt, 000010 srl by shamt; other func = illegal.
REQ-021 I-type: 001000 addi, 001100 andi, 001101 ori, 100011 lw, 101011 sw, 000100 beq, 000101 bne, 000010 j.
REQ-022 addi/lw/sw/beq/bne sign-extend or truncate imm to DATA_W; andi/ori zero-extend.
REQ-023 Add/sub wrap modulo 2^DATA_W; no overflow trap.
REQ-024 Taken branch: pc <= pc + imm (pc already incremented), truncated to PC_W; j: pc <= jaddr zero-extended/truncated to PC_W.
REQ-025 MEM: dmem_req=1 until dmem_ready=1; lw -> WB, sw -> FETCH; unbounded wait states allowed.
REQ-026 WB: write rd (R-type) or rt (I-type) with ALU result or load data -> FETCH.
REQ-027 16 registers; r0 reads 0, writes to r0 discarded.
REQ-028 CPI: branch/jump 3, ALU 4, sw 4+W, lw 5+W, W = wait cycles before dmem_ready.
REQ-029 HALT: no further fetch, pc frozen, halted=1, dmem_req=0 until rst.
REQ-030 dmem_ready outside MEM is ignored.

Reset
REQ-031 rst=1 at a clock edge: state FETCH, pc=0, IR=0, A=B=0, all registers 0, halted=0, dmem_req=0, dmem_we=0.
REQ-032 rst mid-operation (including during MEM wait) aborts the instruction; no register write occurs in that cycle.

Configuration
REQ-033 Macro MIPS_MC_RETIRE_CNT_EN defined: adds output retired (32 bits), reset 0, +1 on each FETCH entry from EXEC/MEM/WB, wraps at 2^32.
REQ-034 Macro undefined: no retired port, no counter logic; all other behaviour identical.

Verification
REQ-035 Reset, then addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r3=0x0002 after 12 cycles, pc=3.
REQ-036 sw r1,4(r0) with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_addr=4, dmem_wdata=5; then lw r4,4(r0) -> r4=5.
REQ-037 beq r1,r1,-1 at pc=7 -> pc=7 after 3 cycles; bne r1,r1,+4 -> pc=8.
REQ-038 Opcode 111111 at pc=2 -> halted=1 at cycle 2 of the instruction, pc=3 frozen; rst -> halted=0, pc=0.
REQ-039 addi r0,r0,9 then add r5,r0,r0 -> r5=0; slt r6,r2,r1 with r2=-3, r1=5 -> r6=1.
REQ-040 With MIPS_MC_RETIRE_CNT_EN, 5 retired instructions -> retired=5; rst asserted in MEM -> retired=0, no register write.
